// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    // Default operand/result width.
    localparam int DIV_WIDTH = 32;

    // Quotient reported on a divide-by-zero: all ones at the default width.
    localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, consumed only while the divider runs.
//
// Ports:
//   rem, quo, divisor   current partial remainder, quotient shift register, divisor magnitude
//   rem_next, quo_next  values after this iteration
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // The partial remainder picks up the next dividend bit; it is one bit
    // wider than an operand because rem < divisor before the shift.
    logic [WIDTH:0] shifted;
    logic           fits;

    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, divisor});

    // When the subtraction fits, the true difference is below the divisor,
    // so the low WIDTH bits of a modular subtract are exact.
    assign rem_next = fits ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: quotient (LO) and remainder (HI), one quotient bit per clock.
// Latency: done pulses WIDTH+1 edges after the accepted start (1 edge for divide-by-zero).
// Backpressure: start is sampled only in IDLE; starts while busy are dropped.
//
// Ports:
//   clk, clr               rising-edge clock; asynchronous active-high reset
//   start, dividend,
//   divisor                request and operands, captured on the accepted start edge
//   quotient, remainder    results, held until the next operation completes
//   busy, done, dz         operation in flight, one-cycle completion pulse, divide-by-zero flag
//
// Build option: define DIV_SIGNED_EN for two's-complement operands (truncating
// division, remainder takes the dividend's sign); otherwise operands are unsigned.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic             dz_pend;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] res_quo;
    logic [WIDTH-1:0] res_rem;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

`ifdef DIV_SIGNED_EN
    logic q_neg;
    logic r_neg;

    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

    // Most-negative / -1 falls out naturally: the magnitude quotient is
    // 2^(WIDTH-1) and the signs match, so no negation is applied.
    assign res_quo = q_neg ? -quo_r : quo_r;
    assign res_rem = r_neg ? -rem_r : rem_r;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (state == IDLE && start) begin
            q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg <= dividend[WIDTH-1];
        end
    end
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign res_quo = quo_r;
    assign res_rem = rem_r;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (div_r),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            div_r     <= '0;
            dz_pend   <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        cnt   <= '0;
                        div_r <= dvs_mag;
                        if (divisor == '0) begin
                            // rem_r carries the raw dividend through to the result.
                            dz_pend <= 1'b1;
                            rem_r   <= dividend;
                            quo_r   <= '0;
                            state   <= DONE;
                        end else begin
                            dz_pend <= 1'b0;
                            rem_r   <= '0;
                            quo_r   <= dvd_mag;
                            state   <= RUN;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    rem_r <= step_rem;
                    quo_r <= step_quo;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // busy stays high through this edge and drops on the
                    // following IDLE edge unless a new start is taken.
                    done <= 1'b1;
                    dz   <= dz_pend;
                    if (dz_pend) begin
                        quotient  <= {WIDTH{DZ_QUOTIENT[0]}};
                        remainder <= rem_r;
                    end else begin
                        quotient  <= res_quo;
                        remainder <= res_rem;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        dz;

    int nvec = 0;
    int nerr = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands for one edge; returns 1ns after the accepting edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges from the accepting edge until done is seen (bounded).
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        clr = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #2;
        nvec++; if (quotient !== 32'd0)  begin nerr++; $display("FAIL reset_quotient got %h want 0", quotient); end
        nvec++; if (remainder !== 32'd0) begin nerr++; $display("FAIL reset_remainder got %h want 0", remainder); end
        nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL reset_done got %b want 0", done); end
        nvec++; if (dz !== 1'b0)         begin nerr++; $display("FAIL reset_dz got %b want 0", dz); end
        repeat (2) @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_basic;
        int lat; bit bok;
        launch(32'd100, 32'd7);
        wait_done(lat, bok);
        nvec++; if (lat !== 33)          begin nerr++; $display("FAIL basic_latency got %0d want 33", lat); end
        nvec++; if (bok !== 1'b1)        begin nerr++; $display("FAIL basic_busy_run got 0 want 1"); end
        nvec++; if (quotient !== 32'd14) begin nerr++; $display("FAIL basic_quotient got %0d want 14", quotient); end
        nvec++; if (remainder !== 32'd2) begin nerr++; $display("FAIL basic_remainder got %0d want 2", remainder); end
        nvec++; if (dz !== 1'b0)         begin nerr++; $display("FAIL basic_dz got %b want 0", dz); end
        nvec++; if (busy !== 1'b1)       begin nerr++; $display("FAIL basic_busy_at_done got %b want 1", busy); end
        @(posedge clk); #1;
        nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL basic_busy_fall got %b want 0", busy); end
        nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL basic_done_pulse got %b want 0", done); end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed;
        int lat; bit bok;
        launch(32'hFFFF_FF9C, 32'd7);
        wait_done(lat, bok);
        nvec++; if (quotient !== 32'hFFFF_FFF2)  begin nerr++; $display("FAIL sneg_quotient got %h want fffffff2", quotient); end
        nvec++; if (remainder !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL sneg_remainder got %h want fffffffe", remainder); end
        launch(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bok);
        nvec++; if (quotient !== 32'h8000_0000)  begin nerr++; $display("FAIL sovf_quotient got %h want 80000000", quotient); end
        nvec++; if (remainder !== 32'd0)         begin nerr++; $display("FAIL sovf_remainder got %h want 0", remainder); end
        nvec++; if (dz !== 1'b0)                 begin nerr++; $display("FAIL sovf_dz got %b want 0", dz); end
    endtask
`else
    task automatic test_unsigned;
        int lat; bit bok;
        launch(32'hFFFF_FFFF, 32'd2);
        wait_done(lat, bok);
        nvec++; if (lat !== 33)                  begin nerr++; $display("FAIL umax_latency got %0d want 33", lat); end
        nvec++; if (quotient !== 32'h7FFF_FFFF)  begin nerr++; $display("FAIL umax_quotient got %h want 7fffffff", quotient); end
        nvec++; if (remainder !== 32'd1)         begin nerr++; $display("FAIL umax_remainder got %h want 1", remainder); end
    endtask
`endif

    task automatic test_div_zero;
        int lat; bit bok;
        launch(32'd1234, 32'd0);
        wait_done(lat, bok);
        nvec++; if (lat !== 1)                   begin nerr++; $display("FAIL dz_latency got %0d want 1", lat); end
        nvec++; if (quotient !== 32'hFFFF_FFFF)  begin nerr++; $display("FAIL dz_quotient got %h want ffffffff", quotient); end
        nvec++; if (remainder !== 32'd1234)      begin nerr++; $display("FAIL dz_remainder got %0d want 1234", remainder); end
        nvec++; if (dz !== 1'b1)                 begin nerr++; $display("FAIL dz_flag got %b want 1", dz); end
        @(posedge clk); #1;
        launch(32'd9, 32'd3);
        nvec++; if (dz !== 1'b1)                 begin nerr++; $display("FAIL dz_hold got %b want 1", dz); end
        wait_done(lat, bok);
        nvec++; if (lat !== 33)                  begin nerr++; $display("FAIL dz_next_latency got %0d want 33", lat); end
        nvec++; if (dz !== 1'b0)                 begin nerr++; $display("FAIL dz_clear got %b want 0", dz); end
        nvec++; if (quotient !== 32'd3)          begin nerr++; $display("FAIL dz_next_quotient got %0d want 3", quotient); end
        nvec++; if (remainder !== 32'd0)         begin nerr++; $display("FAIL dz_next_remainder got %0d want 0", remainder); end
    endtask

    task automatic test_start_while_busy;
        int lat;
        launch(32'd1000, 32'd3);
        lat = 0;
        while (lat < 100) begin
            if (lat == 9) begin
                @(negedge clk);
                dividend = 32'd50;
                divisor  = 32'd5;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (done === 1'b1) break;
        end
        nvec++; if (lat !== 33)            begin nerr++; $display("FAIL busy_start_latency got %0d want 33", lat); end
        nvec++; if (quotient !== 32'd333)  begin nerr++; $display("FAIL busy_start_quotient got %0d want 333", quotient); end
        nvec++; if (remainder !== 32'd1)   begin nerr++; $display("FAIL busy_start_remainder got %0d want 1", remainder); end
        @(posedge clk); #1;
        nvec++; if (busy !== 1'b0)         begin nerr++; $display("FAIL busy_start_idle got %b want 0", busy); end
    endtask

    task automatic test_clear_mid_run;
        int lat; bit bok;
        launch(32'd5000, 32'd7);
        repeat (14) @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL clr_busy got %b want 0", busy); end
        nvec++; if (done !== 1'b0)       begin nerr++; $display("FAIL clr_done got %b want 0", done); end
        nvec++; if (quotient !== 32'd0)  begin nerr++; $display("FAIL clr_quotient got %0d want 0", quotient); end
        nvec++; if (remainder !== 32'd0) begin nerr++; $display("FAIL clr_remainder got %0d want 0", remainder); end
        @(negedge clk);
        clr = 1'b0;
        launch(32'd81, 32'd9);
        wait_done(lat, bok);
        nvec++; if (lat !== 33)          begin nerr++; $display("FAIL clr_next_latency got %0d want 33", lat); end
        nvec++; if (quotient !== 32'd9)  begin nerr++; $display("FAIL clr_next_quotient got %0d want 9", quotient); end
        nvec++; if (remainder !== 32'd0) begin nerr++; $display("FAIL clr_next_remainder got %0d want 0", remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat; bit bok;
        @(negedge clk);
        dividend = 32'd20;
        divisor  = 32'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat, bok);
        nvec++; if (lat !== 33)          begin nerr++; $display("FAIL b2b_first_latency got %0d want 33", lat); end
        nvec++; if (quotient !== 32'd5)  begin nerr++; $display("FAIL b2b_first_quotient got %0d want 5", quotient); end
        wait_done(lat, bok);
        @(negedge clk);
        start = 1'b0;
        nvec++; if (lat !== 34)          begin nerr++; $display("FAIL b2b_retrigger_gap got %0d want 34", lat); end
        nvec++; if (bok !== 1'b1)        begin nerr++; $display("FAIL b2b_busy_continuous got 0 want 1"); end
        nvec++; if (remainder !== 32'd0) begin nerr++; $display("FAIL b2b_second_remainder got %0d want 0", remainder); end
        @(posedge clk); #1;
        nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL b2b_idle got %b want 0", busy); end
    endtask

    initial begin
        test_reset;
        test_basic;
`ifdef DIV_SIGNED_EN
        test_signed;
`else
        test_unsigned;
`endif
        test_div_zero;
        test_start_while_busy;
        test_clear_mid_run;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
